// File: rtl/lap_scheduler_pkg.sv
// Shared types and constants for the lap scheduler: FSM encoding, timestamp layout, packing helper.
// No logic; latency and backpressure are not applicable.
package lap_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_NOTIFY  = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    localparam int TS_W_DEF = 28;
    localparam int UNIT_W   = 7;

    // Unit field positions, counted in UNIT_W-bit fields from the LSB.
    localparam int M_SEC  = 0;
    localparam int SECOND = 1;
    localparam int MINUTE = 2;
    localparam int HOUR   = 3;

    function automatic logic [TS_W_DEF-1:0] ts_pack(input logic [UNIT_W-1:0] hour,
                                                    input logic [UNIT_W-1:0] minute,
                                                    input logic [UNIT_W-1:0] second,
                                                    input logic [UNIT_W-1:0] msec);
        logic [TS_W_DEF-1:0] ts;
        ts = '0;
        ts[HOUR*UNIT_W   +: UNIT_W] = hour;
        ts[MINUTE*UNIT_W +: UNIT_W] = minute;
        ts[SECOND*UNIT_W +: UNIT_W] = second;
        ts[M_SEC*UNIT_W  +: UNIT_W] = msec;
        return ts;
    endfunction

endpackage

// File: rtl/lap_scheduler_if.sv
// Lap scheduler control/LCD bundle; master drives requests and LCD ready, slave is the scheduler.
// Pure wiring; the LCD side uses a req/ready handshake.
interface lap_scheduler_if
    import lap_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF
);
    localparam int IW = $clog2(DEPTH);

    logic            lap_req;
    logic            clear_req;
    logic            recall_next;
    logic [TS_W-1:0] timestamp;
    logic            reg_busy;
    logic            lcd_ready;
    logic            lcd_req;
    logic [IW-1:0]   lcd_index;
    logic [TS_W-1:0] lcd_data;
    logic [IW-1:0]   recall_index;
    logic [TS_W-1:0] recall_data;
    logic [IW:0]     lap_count;
    logic            full;
    logic            busy;

    modport master (
        output lap_req, clear_req, recall_next, timestamp, reg_busy, lcd_ready,
        input  lcd_req, lcd_index, lcd_data, recall_index, recall_data, lap_count, full, busy
    );

    modport slave (
        input  lap_req, clear_req, recall_next, timestamp, reg_busy, lcd_ready,
        output lcd_req, lcd_index, lcd_data, recall_index, recall_data, lap_count, full, busy
    );

endinterface

// File: rtl/lap_regfile.sv
// DEPTH x TS_W slot storage, one synchronous write port and two asynchronous read ports.
// Write lands on the next edge, reads are combinational; no backpressure.
module lap_regfile
    import lap_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [TS_W-1:0] wdata,
    input  logic [IW-1:0]   raddr_a,
    output logic [TS_W-1:0] rdata_a,
    input  logic [IW-1:0]   raddr_b,
    output logic [TS_W-1:0] rdata_b
);

    logic [TS_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lap_scheduler.sv
// Captures lap timestamps into a circular buffer, offers each to the LCD, supports recall and clear.
// Capture 2 cycles after lap_req when reg_busy low; LCD offer held until lcd_ready, one pending lap merged.
module lap_scheduler
    import lap_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    lap_scheduler_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   wr_ptr, clr_cnt, lcd_idx, recall_idx;
    logic [CW-1:0]   lap_cnt;
    logic            pending;
    logic            we;
    logic [IW-1:0]   waddr;
    logic [TS_W-1:0] wdata;
    logic            clr_last;

    assign clr_last = (state == ST_CLEAR) && (clr_cnt == IW'(DEPTH - 1));

    // Clear has priority everywhere outside CLEAR; in CAPTURE the write still completes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (bus.clear_req)                  state_nxt = ST_CLEAR;
                        else if (bus.lap_req || pending)    state_nxt = ST_SYNC;
            ST_SYNC:    if (bus.clear_req)                  state_nxt = ST_CLEAR;
                        else if (!bus.reg_busy)             state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (bus.clear_req)                  state_nxt = ST_CLEAR;
                        else                                state_nxt = ST_NOTIFY;
            ST_NOTIFY:  if (bus.clear_req)                  state_nxt = ST_CLEAR;
                        else if (bus.lcd_ready)             state_nxt = ST_IDLE;
            ST_CLEAR:   if (clr_last)                       state_nxt = ST_IDLE;
            default:                                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        we    = (state == ST_CAPTURE) || (state == ST_CLEAR);
        waddr = (state == ST_CAPTURE) ? wr_ptr : clr_cnt;
        wdata = (state == ST_CAPTURE) ? bus.timestamp : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            clr_cnt    <= '0;
            lcd_idx    <= '0;
            recall_idx <= '0;
            lap_cnt    <= '0;
            pending    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_CAPTURE) begin
                wr_ptr  <= wr_ptr + IW'(1);
                lcd_idx <= wr_ptr;
                if (lap_cnt != CW'(DEPTH)) lap_cnt <= lap_cnt + CW'(1);
            end

            if (state == ST_CLEAR) clr_cnt <= clr_cnt + IW'(1);
            else                   clr_cnt <= '0;

            if (clr_last) begin
                wr_ptr     <= '0;
                lap_cnt    <= '0;
                recall_idx <= '0;
            end else if (bus.recall_next && (lap_cnt != '0) && (state != ST_CLEAR)) begin
                if ({1'b0, recall_idx} + CW'(1) == lap_cnt) recall_idx <= '0;
                else                                      recall_idx <= recall_idx + IW'(1);
            end

            if (bus.clear_req && (state != ST_CLEAR))               pending <= 1'b0;
            else if (state == ST_IDLE)                              pending <= 1'b0;
            else if ((state != ST_CLEAR) && bus.lap_req)            pending <= 1'b1;
        end
    end

    lap_regfile #(.DEPTH(DEPTH), .TS_W(TS_W)) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (lcd_idx),
        .rdata_a (bus.lcd_data),
        .raddr_b (recall_idx),
        .rdata_b (bus.recall_data)
    );

    assign bus.lcd_req      = (state == ST_NOTIFY);
    assign bus.lcd_index    = lcd_idx;
    assign bus.recall_index = recall_idx;
    assign bus.lap_count    = lap_cnt;
    assign bus.full         = (lap_cnt == CW'(DEPTH));
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_lap_scheduler.sv
// Randomized and directed bench for lap_scheduler against a behavioural lap/clear model.
module tb_lap_scheduler;
    import lap_scheduler_pkg::*;

    localparam int DEPTH = 8;
    localparam int TS_W  = TS_W_DEF;

    localparam int LAP_NONE  = 0;
    localparam int LAP_WAIT  = 1;
    localparam int LAP_TAKE  = 2;
    localparam int LAP_OFFER = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    lap_scheduler_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();
    lap_scheduler #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [TS_W-1:0] m_slot [DEPTH];
    int  m_wr, m_cnt, m_rec, m_offer, m_stage, m_clear_left;
    bit  m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
        m_wr = 0; m_cnt = 0; m_rec = 0; m_offer = 0;
        m_stage = LAP_NONE; m_clear_left = 0; m_pend = 1'b0;
    endtask

    // One clock edge of lap bookkeeping, from the inputs present at that edge.
    task automatic model_step();
        if (m_clear_left > 0) begin
            m_slot[DEPTH - m_clear_left] = '0;
            m_clear_left--;
            if (m_clear_left == 0) begin
                m_wr = 0; m_cnt = 0; m_rec = 0;
            end
            return;
        end
        if (bus.recall_next && m_cnt > 0) m_rec = (m_rec + 1) % m_cnt;
        if (m_stage == LAP_TAKE) begin
            m_slot[m_wr] = bus.timestamp;
            m_offer = m_wr;
            m_wr = (m_wr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
        end
        if (bus.clear_req) begin
            m_stage = LAP_NONE; m_pend = 1'b0; m_clear_left = DEPTH;
            return;
        end
        case (m_stage)
            LAP_NONE: if (bus.lap_req || m_pend) begin m_stage = LAP_WAIT; m_pend = 1'b0; end
            LAP_WAIT: begin
                if (bus.lap_req) m_pend = 1'b1;
                if (!bus.reg_busy) m_stage = LAP_TAKE;
            end
            LAP_TAKE: begin
                if (bus.lap_req) m_pend = 1'b1;
                m_stage = LAP_OFFER;
            end
            default: begin
                if (bus.lap_req) m_pend = 1'b1;
                if (bus.lcd_ready) m_stage = LAP_NONE;
            end
        endcase
    endtask

    task automatic check_all();
        chk("lcd_req",      32'(bus.lcd_req),      32'(m_stage == LAP_OFFER));
        chk("lcd_index",    32'(bus.lcd_index),    32'(m_offer));
        chk("lcd_data",     32'(bus.lcd_data),     32'(m_slot[m_offer]));
        chk("recall_index", 32'(bus.recall_index), 32'(m_rec));
        chk("recall_data",  32'(bus.recall_data),  32'(m_slot[m_rec]));
        chk("lap_count",    32'(bus.lap_count),    32'(m_cnt));
        chk("full",         32'(bus.full),         32'(m_cnt == DEPTH));
        chk("busy",         32'(bus.busy),         32'(m_stage != LAP_NONE || m_clear_left != 0));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [TS_W-1:0] rand_ts();
        return ts_pack(7'($urandom_range(23)), 7'($urandom_range(59)),
                       7'($urandom_range(59)), 7'($urandom_range(99)));
    endfunction

    task automatic do_lap(input logic [TS_W-1:0] ts);
        bus.timestamp = ts; bus.reg_busy = 1'b0; bus.lcd_ready = 1'b1;
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        tick(); tick();
        chk("lap_offer", 32'(bus.lcd_req), 32'd1);
        tick();
    endtask

    task automatic do_clear();
        bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
        repeat (DEPTH) tick();
    endtask

    logic [TS_W-1:0] ts_a, ts_b, held;
    logic [TS_W-1:0] lap_ts [9];
    int exp_seq [4];

    initial begin
        bus.lap_req = 1'b0; bus.clear_req = 1'b0; bus.recall_next = 1'b0;
        bus.timestamp = '0; bus.reg_busy = 1'b0; bus.lcd_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // First capture: two cycles after the request, into slot 0.
        bus.timestamp = 28'h0123456;
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        tick();
        chk("r21_no_write_yet", 32'(bus.lap_count), 32'd0);
        tick();
        chk("r21_slot0",     32'(bus.recall_data), 32'h0123456);
        chk("r21_count",     32'(bus.lap_count),   32'd1);
        chk("r21_lcd_req",   32'(bus.lcd_req),     32'd1);
        chk("r21_lcd_index", 32'(bus.lcd_index),   32'd0);
        bus.lcd_ready = 1'b1; tick(); bus.lcd_ready = 1'b0;

        // reg_busy holds off the capture; the value after it falls is taken.
        bus.reg_busy = 1'b1;
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        for (int i = 0; i < 4; i++) begin bus.timestamp = rand_ts(); tick(); end
        chk("r22_held", 32'(bus.lap_count), 32'd1);
        ts_a = rand_ts(); ts_b = ts_a ^ 28'h1;
        bus.reg_busy = 1'b0; bus.timestamp = ts_a; tick();
        bus.timestamp = ts_b; tick();
        chk("r22_value", 32'(bus.lcd_data),  32'(ts_b));
        chk("r22_index", 32'(bus.lcd_index), 32'd1);
        bus.lcd_ready = 1'b1; tick();

        // Wrap-around: nine laps in an eight-slot buffer.
        do_clear();
        for (int i = 0; i < 9; i++) begin lap_ts[i] = rand_ts(); do_lap(lap_ts[i]); end
        chk("r23_full",    32'(bus.full),      32'd1);
        chk("r23_count",   32'(bus.lap_count), 32'd8);
        chk("r23_slot0",   32'(bus.lcd_index), 32'd0);
        chk("r23_data",    32'(bus.lcd_data),  32'(lap_ts[8]));
        do_lap(rand_ts());
        chk("r23_wr_ptr",  32'(bus.lcd_index), 32'd1);

        // Stalled LCD with a second lap merged as pending.
        ts_a = rand_ts(); ts_b = rand_ts();
        bus.lcd_ready = 1'b0; bus.timestamp = ts_a;
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        tick(); tick();
        held = bus.lcd_data;
        chk("r24_first", 32'(held), 32'(ts_a));
        for (int i = 0; i < 10; i++) begin
            bus.lap_req = (i == 3);
            bus.timestamp = rand_ts();
            tick();
            chk("r24_stable", 32'(bus.lcd_data), 32'(held));
        end
        bus.lap_req = 1'b0; bus.timestamp = ts_b; bus.lcd_ready = 1'b1;
        repeat (4) tick();
        chk("r24_second_req",  32'(bus.lcd_req),  32'd1);
        chk("r24_second_data", 32'(bus.lcd_data), 32'(ts_b));
        tick();

        // Clear during NOTIFY.
        bus.lcd_ready = 1'b0; bus.timestamp = rand_ts();
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        tick(); tick();
        chk("r25_notify", 32'(bus.lcd_req), 32'd1);
        bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
        chk("r25_lcd_drop", 32'(bus.lcd_req), 32'd0);
        repeat (DEPTH - 1) tick();
        chk("r25_clear_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("r25_idle",  32'(bus.busy),      32'd0);
        chk("r25_count", 32'(bus.lap_count), 32'd0);

        // Recall walks modulo the lap count.
        for (int i = 0; i < 3; i++) do_lap(rand_ts());
        exp_seq = '{1, 2, 0, 1};
        for (int i = 0; i < 4; i++) begin
            bus.recall_next = 1'b1; tick(); bus.recall_next = 1'b0;
            chk("r26_recall", 32'(bus.recall_index), 32'(exp_seq[i]));
        end

        // Reset in the middle of an LCD offer.
        bus.lcd_ready = 1'b0;
        bus.lap_req = 1'b1; tick(); bus.lap_req = 1'b0;
        tick(); tick();
        chk("rst_pre_notify", 32'(bus.lcd_req), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_lcd_req", 32'(bus.lcd_req),   32'd0);
        chk("rst_busy",    32'(bus.busy),      32'd0);
        chk("rst_count",   32'(bus.lap_count), 32'd0);
        model_reset();
        #1 reset_n = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            bus.lap_req     = ($urandom_range(7) == 0);
            bus.clear_req   = ($urandom_range(59) == 0);
            bus.recall_next = ($urandom_range(5) == 0);
            if ($urandom_range(3) == 0) bus.reg_busy = ~bus.reg_busy;
            bus.lcd_ready   = 1'($urandom_range(1));
            bus.timestamp   = rand_ts();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_scheduler.md
LAP_SCHEDULER -- requirements
Module: lap_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of lap entries (power of two, 2..16).
REQ-002 Parameter TS_W, default 28, SHALL set the timestamp width (4 units x 7 bits: hour, minute, second, m_sec from MSB to LSB).
REQ-003 Port list SHALL be as follows:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lap_req  in  1  one-cycle pulse requesting a lap capture.
- clear_req  in  1  one-cycle pulse requesting erase of all laps.
- recall_next  in  1  one-cycle pulse advancing the recall pointer.
- timestamp  in  TS_W  live timer value.
- reg_busy  in  1  high while the timer is updating timestamp; the value is unstable then.
- lcd_ready  in  1  LCD writer accepts a transfer.
- lcd_req  out  1  a lap record is offered to the LCD writer.
- lcd_index  out  clog2(DEPTH)  lap slot of the offered record.
- lcd_data  out  TS_W  offered lap timestamp.
- recall_index  out  clog2(DEPTH)  slot currently shown by recall.
- recall_data  out  TS_W  timestamp stored in recall_index.
- lap_count  out  clog2(DEPTH)+1  number of valid laps (0..DEPTH).
- full  out  1  lap_count == DEPTH.
- busy  out  1  FSM not in IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, SYNC, CAPTURE, NOTIFY and CLEAR.
REQ-005 In IDLE, a clear_req SHALL go to CLEAR; otherwise a lap_req SHALL go to SYNC; if both pulse in the same cycle, clear SHALL win and the lap SHALL be dropped.
REQ-006 SYNC SHALL wait until reg_busy is low, then go to CAPTURE on the next edge; capture latency SHALL be 2 cycles after lap_req when reg_busy is low.
REQ-007 CAPTURE SHALL write timestamp to slot wr_ptr, increment wr_ptr modulo DEPTH, and saturate lap_count at DEPTH, all in one cycle; it SHALL then go to NOTIFY.
REQ-008 When full, a new capture SHALL overwrite the oldest slot (circular buffer); full SHALL remain high.
REQ-009 NOTIFY SHALL hold lcd_req high with lcd_index and lcd_data stable until the cycle where lcd_req and lcd_ready are both high; it SHALL return to IDLE on the following edge.
REQ-010 A lap_req arriving while busy SHALL be latched as one pending request (further pulses merged) and serviced on return to IDLE.
REQ-011 A clear_req arriving in SYNC or NOTIFY SHALL abort the operation (lcd_req drops next cycle), discard the pending lap, and enter CLEAR.
REQ-012 CLEAR SHALL zero one slot per cycle for DEPTH cycles, then reset wr_ptr, recall_index and lap_count to 0 and return to IDLE; lap_req during CLEAR SHALL be ignored.
REQ-013 recall_next SHALL advance recall_index modulo max(lap_count,1), and SHALL be ignored when lap_count is 0 or the FSM is in CLEAR.
REQ-014 recall_data SHALL be a combinational read of slot recall_index; after a capture, recall_index SHALL be left unchanged.

Reset
REQ-015 On reset_n low, the following SHALL hold asynchronously: state=IDLE, wr_ptr=0, recall_index=0, lap_count=0, pending=0, lcd_req=0, and all slots 0.
REQ-016 After reset, all outputs SHALL be 0.
REQ-017 Reset release SHALL take effect on the first rising edge with reset_n high.
REQ-018 Reset asserted mid-NOTIFY SHALL drop lcd_req immediately, with no handshake completed.

Structure
REQ-019 A shared package SHALL hold the state encoding, the TS_W default and the unit field offsets (M_SEC=0, SECOND=1, MINUTE=2, HOUR=3).
REQ-020 The slot storage SHALL be one sub-module, lap_regfile: a DEPTH x TS_W register array with one write port and two asynchronous read ports.

Verification
REQ-021 Reset, then lap_req with timestamp=0x0123456 and reg_busy=0 -> slot0=0x0123456 two cycles later, lap_count=1, lcd_req=1 with lcd_index=0.
REQ-022 lap_req with reg_busy held high for 5 cycles -> no write until reg_busy falls; the value captured is the one present in the cycle after it falls.
REQ-023 Nine laps with DEPTH=8 -> full=1, lap_count=8, slot0 overwritten by lap 9, wr_ptr=1.
REQ-024 lcd_ready held low for 10 cycles during NOTIFY, with a second lap_req arriving -> lcd_data stays stable; the second lap is captured after the handshake.
REQ-025 clear_req during NOTIFY -> lcd_req=0 next cycle, CLEAR lasts 8 cycles, then lap_count=0 and all slots 0.
REQ-026 Three laps, then four recall_next pulses -> recall_index sequence 1, 2, 0, 1.
